// File: rtl/axi_pkg.sv
// Shared AXI write-path types: burst/size/response encodings, FSM states
// and the byte-lane mask helper used for narrow transfers.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } size_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_t;

  // Widest strobe bus supported (1024-bit data).
  localparam int MAX_STRB = 128;

  // Sets lanes lo..hi inclusive; callers truncate to their strobe width.
  function automatic logic [MAX_STRB-1:0] lane_mask(input logic [7:0] lo, input logic [7:0] hi);
    logic [MAX_STRB-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_STRB; i++) begin
      m[i] = (8'(i) >= lo) && (8'(i) <= hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_cur_addr,
  input  size_t                 i_size,
  input  burst_t                i_burst,
  input  logic [7:0]            i_len,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] w_bytes;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [ADDR_WIDTH-1:0] w_wrap_bytes;
  logic [ADDR_WIDTH-1:0] w_lower;
  logic [ADDR_WIDTH-1:0] w_step;

  assign w_bytes      = ONE << i_size;
  assign w_aligned    = i_cur_addr & ~(w_bytes - ONE);
  assign w_wrap_bytes = ADDR_WIDTH'({1'b0, i_len} + 9'd1) << i_size;
  assign w_lower      = i_cur_addr & ~(w_wrap_bytes - ONE);
  assign w_step       = i_cur_addr + w_bytes;

  // INCR realigns after an unaligned first beat; WRAP folds back at the window top.
  always_comb begin
    o_next_addr = i_cur_addr;
    case (i_burst)
      BURST_INCR: o_next_addr = w_aligned + w_bytes;
      BURST_WRAP: o_next_addr = (w_step == w_lower + w_wrap_bytes) ? w_lower : w_step;
      default:    o_next_addr = i_cur_addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_burst_slv.sv
// AXI4 write-burst slave: AW/W/B handshakes, per-beat memory write port,
// narrow-transfer strobe masking and SLVERR/DECERR classification.
module axi_wr_burst_slv
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  input  logic [STRB_WIDTH-1:0]        WSTRB,
  input  logic                         WLAST,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [1:0]                   BRESP,
  output logic                         mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [STRB_WIDTH-1:0]        mem_wstrb
);

  localparam int STRB_LSB = $clog2(STRB_WIDTH);
  localparam int MEM_AW   = $clog2(MEM_DEPTH);
  localparam int WA_W     = ADDR_WIDTH - STRB_LSB;
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] STRB_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  wr_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  size_t                 r_size;
  burst_t                r_burst;
  logic [7:0]            r_beat_cnt;
  logic                  r_aw_err;
  logic                  r_prot_err;
  logic                  r_range_err;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  resp_t                 r_bresp;

  logic                  w_aw_err;
  logic                  w_w_hs;
  logic                  w_is_last;
  logic                  w_last_err;
  logic                  w_in_range;
  logic                  w_prot_now;
  logic                  w_range_now;
  logic [WA_W-1:0]       w_word_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_beat_bytes;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [7:0]            w_lane_lo;
  logic [7:0]            w_lane_hi;
  logic [STRB_WIDTH-1:0] w_lane_mask;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_cur_addr  (r_addr),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .i_len       (r_len),
    .o_next_addr (w_next_addr)
  );

  // Burst-level errors are decided from the AW channel alone.
  assign w_aw_err = (32'(AWSIZE) > STRB_LSB)
                 || (AWBURST == BURST_RSVD)
                 || ((AWBURST == BURST_WRAP) &&
                     !(AWLEN == 8'd1 || AWLEN == 8'd3 || AWLEN == 8'd7 || AWLEN == 8'd15))
                 || ((AWBURST == BURST_WRAP) && ((AWADDR & ((ONE << AWSIZE) - ONE)) != '0));

  assign w_w_hs      = r_wready && WVALID;
  assign w_is_last   = (r_beat_cnt == r_len);
  assign w_last_err  = w_w_hs && (WLAST != w_is_last);
  assign w_word_addr = r_addr[ADDR_WIDTH-1:STRB_LSB];
  assign w_in_range  = ({1'b0, w_word_addr} < (WA_W + 1)'(MEM_DEPTH));
  assign w_prot_now  = r_prot_err || w_last_err;
  assign w_range_now = r_range_err || !w_in_range;

  assign w_beat_bytes = ONE << r_size;
  assign w_aligned    = r_addr & ~(w_beat_bytes - ONE);
  assign w_lane_lo    = 8'(r_addr & STRB_MASK);
  assign w_lane_hi    = 8'(w_aligned & STRB_MASK) + 8'(w_beat_bytes - ONE);
  assign w_lane_mask  = STRB_WIDTH'(lane_mask(w_lane_lo, w_lane_hi));

  assign mem_we    = w_w_hs && !r_aw_err && w_in_range;
  assign mem_addr  = MEM_AW'(w_word_addr);
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB & w_lane_mask;

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= SIZE_1B;
      r_burst     <= BURST_FIXED;
      r_beat_cnt  <= '0;
      r_aw_err    <= 1'b0;
      r_prot_err  <= 1'b0;
      r_range_err <= 1'b0;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (AWVALID && r_awready) begin
            r_addr      <= AWADDR;
            r_len       <= AWLEN;
            r_size      <= size_t'(AWSIZE);
            r_burst     <= burst_t'(AWBURST);
            r_beat_cnt  <= '0;
            r_aw_err    <= w_aw_err;
            r_prot_err  <= w_aw_err;
            r_range_err <= 1'b0;
            r_awready   <= 1'b0;
            r_wready    <= 1'b1;
            r_state     <= ST_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_w_hs) begin
            r_addr      <= w_next_addr;
            r_beat_cnt  <= r_beat_cnt + 8'd1;
            r_prot_err  <= w_prot_now;
            r_range_err <= w_range_now;
            // Early WLAST also closes the burst; that beat was still written.
            if (w_is_last || WLAST) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_prot_now  ? RESP_SLVERR :
                          w_range_now ? RESP_DECERR : RESP_OKAY;
              r_state  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_wr_burst_slv.md
Name: axi_wr_burst_slv

Overview:
- Parametrised AXI4 write-path slave engine for the dual-port memory subsystem.
- Accepts a write address (AW) burst, consumes W beats, and generates per-beat word addresses for FIXED, INCR and WRAP bursts.
- Masks byte strobes for narrow transfers, drives a memory write port, and returns a B response with error classification.
- Successor to the AXI-lite write path: adds bursts, narrow sizes, width/depth parameters and error responses.

Parameters:
- ADDR_WIDTH, 32, byte-address width of AWADDR.
- DATA_WIDTH, 32, W data bus width in bits; must be a power of two, 8..1024.
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH-wide words.
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width (derived).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWADDR  in  ADDR_WIDTH  burst start byte address
- AWLEN  in  8  beats minus one
- AWSIZE  in  3  bytes per beat = 2**AWSIZE
- AWBURST  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  STRB_WIDTH  byte strobes
- WLAST  in  1  last beat marker
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- BRESP  out  2  0 OKAY, 2 SLVERR, 3 DECERR
- mem_we  out  1  memory write enable, one cycle per accepted beat
- mem_addr  out  $clog2(MEM_DEPTH)  word address
- mem_wdata  out  DATA_WIDTH  WDATA passthrough
- mem_wstrb  out  STRB_WIDTH  lane-masked strobes

Behaviour:
- Reset (asynchronous, ARESETn=0): state IDLE; AWREADY=0, WREADY=0, BVALID=0, BRESP=0, mem_we=0; all latched burst registers cleared.
- Released from reset: AWREADY=1 only in IDLE.
- FSM IDLE -> DATA -> RESP -> IDLE.
- IDLE:
  - AWREADY=1.
  - On AWVALID&&AWREADY, latch addr, len, size and burst; clear beat_cnt and the error flags; go to DATA next cycle.
- DATA:
  - WREADY=1.
  - On each W handshake, mem_we=1 combinationally in the same cycle, with mem_addr = cur_addr[ADDR_WIDTH-1:log2(STRB_WIDTH)].
  - mem_wstrb = WSTRB AND lane mask for bytes [cur_addr mod STRB_WIDTH, aligned_to_size(cur_addr) + 2**size - 1].
- Address update after each beat:
  - FIXED: unchanged.
  - INCR: cur_addr = aligned_to_size(cur_addr) + 2**size; the first beat may be unaligned; the sum wraps modulo 2**ADDR_WIDTH; no 4 KB check.
  - WRAP: wrap_bytes = (len+1) << size; lower = cur_addr aligned down to wrap_bytes; next = cur_addr + 2**size; if next == lower + wrap_bytes, next = lower.
- Protocol error (prot_err, sticky) is set by any of:
  - AWSIZE > log2(STRB_WIDTH)
  - AWBURST=3
  - WRAP with len not in {1,3,7,15}
  - WRAP with start address not size-aligned
  - WLAST asserted before beat_cnt==len
  - WLAST deasserted on beat_cnt==len
- Beat suppression:
  - If prot_err was set at AW time, every beat of the burst is consumed with mem_we=0.
  - A beat whose word address >= MEM_DEPTH is consumed with mem_we=0 and sets range_err (sticky).
- Burst termination: on the beat where beat_cnt==len, or on an early WLAST, go to RESP. An early-WLAST beat is still written if otherwise legal.
- RESP:
  - BVALID=1; BRESP = SLVERR if prot_err, else DECERR if range_err, else OKAY.
  - Hold BVALID and BRESP stable until BREADY.
  - On BVALID&&BREADY, go to IDLE next cycle.
  - AWREADY=0 and WREADY=0 throughout RESP.
- Throughput: one beat per cycle. Minimum burst latency is AW handshake -> first WREADY 1 cycle, last beat -> BVALID 1 cycle.
- WVALID in IDLE is not accepted (WREADY=0); data is held by the master.

Decomposition:
- axi_pkg (shared): burst_t, size_t, resp_t enums with constants BURST_FIXED/INCR/WRAP and RESP_OKAY/SLVERR/DECERR, plus a lane-mask helper function.
- Sub-module axi_burst_addr_gen: purely combinational next-address calculation from (cur_addr, size, burst, len), instantiated once. The FSM, counters and error logic stay in axi_wr_burst_slv.

Test Plan:
- INCR, AWADDR=0x10, AWLEN=3, AWSIZE=2, DATA_WIDTH=32, all WSTRB=0xF -> mem_addr 4,5,6,7 with mem_we each beat; BRESP=OKAY; BVALID one cycle after beat 4.
- WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 -> byte addresses 0x38, 0x3C, 0x30, 0x34 (word 14,15,12,13); BRESP=OKAY.
- Narrow INCR, AWADDR=0x1, AWSIZE=0, AWLEN=2, WSTRB=0xF -> mem_wstrb 0x2, 0x4, 0x8; all at word 0.
- Early WLAST on beat 2 of AWLEN=3 -> two writes, state RESP after beat 2, BRESP=SLVERR. Separately, AWADDR=MEM_DEPTH*4 -> no mem_we, BRESP=DECERR.
- BREADY held low 5 cycles -> BVALID/BRESP stable and AWREADY=0 throughout. ARESETn pulsed low mid-burst -> immediate IDLE outputs; the next burst completes with OKAY.
